// File: rtl/mem_access.sv
// MEM-stage data-memory access unit: alignment checking, AdEL/AdES flagging,
// a single SRAM-like request per load/store, and load-data extension.
module mem_access #(
  parameter int unsigned EXC_ADEL_BIT = 28,
  parameter int unsigned EXC_ADES_BIT = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] exception_type_i,
  input  logic        regfile_write_enable_i,
  input  logic        advance_i,
  input  logic        flush_i,
  output logic        data_req_o,
  output logic        data_wr_o,
  output logic [1:0]  data_size_o,
  output logic [31:0] data_addr_o,
  output logic [3:0]  data_wstrb_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_addr_ok_i,
  input  logic        data_data_ok_i,
  input  logic [31:0] data_rdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] exception_type_o,
  output logic [31:0] bad_vaddr_o,
  output logic        regfile_write_enable_o,
  output logic        mem_stall_request_o
);

  localparam logic [7:0] ALUOP_LB  = 8'b1110_0000;
  localparam logic [7:0] ALUOP_LH  = 8'b1110_0001;
  localparam logic [7:0] ALUOP_LW  = 8'b1110_0011;
  localparam logic [7:0] ALUOP_LBU = 8'b1110_0100;
  localparam logic [7:0] ALUOP_LHU = 8'b1110_0101;
  localparam logic [7:0] ALUOP_SB  = 8'b1110_1000;
  localparam logic [7:0] ALUOP_SH  = 8'b1110_1001;
  localparam logic [7:0] ALUOP_SW  = 8'b1110_1011;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state;
  logic        cancel;
  logic [1:0]  off_q;
  logic [7:0]  aluop_q;

  logic        is_load;
  logic        is_store;
  logic [1:0]  size_c;
  logic        misaligned;
  logic        adel;
  logic        ades;
  logic        start;
  logic [3:0]  wstrb_c;
  logic [31:0] wdata_c;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // Decode the incoming aluop into access kind and size.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size_c   = 2'd0;
    case (aluop_i)
      ALUOP_LB, ALUOP_LBU: begin is_load  = 1'b1; size_c = 2'd0; end
      ALUOP_LH, ALUOP_LHU: begin is_load  = 1'b1; size_c = 2'd1; end
      ALUOP_LW:            begin is_load  = 1'b1; size_c = 2'd2; end
      ALUOP_SB:            begin is_store = 1'b1; size_c = 2'd0; end
      ALUOP_SH:            begin is_store = 1'b1; size_c = 2'd1; end
      ALUOP_SW:            begin is_store = 1'b1; size_c = 2'd2; end
      default: ;
    endcase
  end

  assign misaligned = ((size_c == 2'd1) && mem_addr_i[0]) ||
                      ((size_c == 2'd2) && (mem_addr_i[1:0] != 2'b00));
  assign adel = valid_i & is_load  & misaligned;
  assign ades = valid_i & is_store & misaligned;

  assign exception_type_o = exception_type_i
                          | (32'(adel) << EXC_ADEL_BIT)
                          | (32'(ades) << EXC_ADES_BIT);
  assign bad_vaddr_o            = misaligned ? mem_addr_i : '0;
  assign regfile_write_enable_o = regfile_write_enable_i & ~adel;

  assign start = valid_i & (is_load | is_store) & ~misaligned
               & (exception_type_i == '0) & ~flush_i;

  // Store byte enables and lane-replicated write data.
  always_comb begin
    wstrb_c = '0;
    wdata_c = store_data_i;
    case (aluop_i)
      ALUOP_SB: begin
        wstrb_c = 4'b0001 << mem_addr_i[1:0];
        wdata_c = {4{store_data_i[7:0]}};
      end
      ALUOP_SH: begin
        wstrb_c = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{store_data_i[15:0]}};
      end
      ALUOP_SW: wstrb_c = 4'b1111;
      default: ;
    endcase
  end

  // Extend returned read data using the latched op and byte offset.
  always_comb begin
    byte_sel = data_rdata_i[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    case (aluop_q)
      ALUOP_LB:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      ALUOP_LBU: load_ext = {24'b0, byte_sel};
      ALUOP_LH:  load_ext = {{16{half_sel[15]}}, half_sel};
      ALUOP_LHU: load_ext = {16'b0, half_sel};
      default:   load_ext = data_rdata_i;
    endcase
  end

  // Request FSM: request fields are held until addr_ok; a flush only marks
  // the access cancelled so the in-flight response is still absorbed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cancel       <= 1'b0;
      off_q        <= '0;
      aluop_q      <= '0;
      load_data_o  <= '0;
      data_req_o   <= 1'b0;
      data_wr_o    <= 1'b0;
      data_size_o  <= '0;
      data_addr_o  <= '0;
      data_wstrb_o <= '0;
      data_wdata_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_REQ;
            cancel       <= 1'b0;
            data_req_o   <= 1'b1;
            data_wr_o    <= is_store;
            data_size_o  <= size_c;
            data_addr_o  <= mem_addr_i;
            data_wstrb_o <= wstrb_c;
            data_wdata_o <= wdata_c;
            off_q        <= mem_addr_i[1:0];
            aluop_q      <= aluop_i;
          end
        end
        S_REQ: begin
          if (flush_i) cancel <= 1'b1;
          if (data_addr_ok_i) begin
            data_req_o <= 1'b0;
            if (data_data_ok_i) begin
              cancel <= 1'b0;
              if (cancel || flush_i) begin
                state <= S_IDLE;
              end else begin
                state <= S_DONE;
                if (!data_wr_o) load_data_o <= load_ext;
              end
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (flush_i) cancel <= 1'b1;
          if (data_data_ok_i) begin
            cancel <= 1'b0;
            if (cancel || flush_i) begin
              state <= S_IDLE;
            end else begin
              state <= S_DONE;
              if (!data_wr_o) load_data_o <= load_ext;
            end
          end
        end
        S_DONE: begin
          if (advance_i || flush_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem_stall_request_o = ((state == S_IDLE) && start) ||
                               (state == S_REQ) || (state == S_WAIT);

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: a memory responder checks each request against a
// queue of expected requests; load results are checked against a queue of
// expected values when the access completes.
module tb_mem_access;

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i;
  logic [31:0] store_data_i;
  logic [31:0] exception_type_i;
  logic        regfile_write_enable_i;
  logic        advance_i;
  logic        flush_i;
  logic        data_req_o;
  logic        data_wr_o;
  logic [1:0]  data_size_o;
  logic [31:0] data_addr_o;
  logic [3:0]  data_wstrb_o;
  logic [31:0] data_wdata_o;
  logic        data_addr_ok_i;
  logic        data_data_ok_i;
  logic [31:0] data_rdata_i;
  logic [31:0] load_data_o;
  logic [31:0] exception_type_o;
  logic [31:0] bad_vaddr_o;
  logic        regfile_write_enable_o;
  logic        mem_stall_request_o;

  mem_access #(.EXC_ADEL_BIT(28), .EXC_ADES_BIT(27)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i),
    .mem_addr_i(mem_addr_i), .store_data_i(store_data_i),
    .exception_type_i(exception_type_i),
    .regfile_write_enable_i(regfile_write_enable_i),
    .advance_i(advance_i), .flush_i(flush_i),
    .data_req_o(data_req_o), .data_wr_o(data_wr_o), .data_size_o(data_size_o),
    .data_addr_o(data_addr_o), .data_wstrb_o(data_wstrb_o),
    .data_wdata_o(data_wdata_o), .data_addr_ok_i(data_addr_ok_i),
    .data_data_ok_i(data_data_ok_i), .data_rdata_i(data_rdata_i),
    .load_data_o(load_data_o), .exception_type_o(exception_type_o),
    .bad_vaddr_o(bad_vaddr_o), .regfile_write_enable_o(regfile_write_enable_o),
    .mem_stall_request_o(mem_stall_request_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int unsigned len;
  } req_t;

  req_t        req_q[$];
  logic [31:0] ld_q[$];
  int unsigned dok_delay;
  logic [31:0] cur_rdata;
  logic [31:0] last_ld;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic m_store(input logic [7:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [1:0] m_size(input logic [7:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 2'd0;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [3:0] m_strb(input logic [7:0] op, input logic [1:0] off);
    if (op == OP_SB) return 4'b0001 << off;
    if (op == OP_SH) return off[1] ? 4'b1100 : 4'b0011;
    if (op == OP_SW) return 4'b1111;
    return 4'b0000;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] d);
    if (op == OP_SB) return {4{d[7:0]}};
    if (op == OP_SH) return {2{d[15:0]}};
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [7:0] op, input logic [1:0] off,
                                         input logic [31:0] rd);
    logic [31:0] t;
    logic [15:0] h;
    t = rd >> (8 * off);
    h = off[1] ? rd[31:16] : rd[15:0];
    case (op)
      OP_LB:   return {{24{t[7]}}, t[7:0]};
      OP_LBU:  return {24'b0, t[7:0]};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'b0, h};
      default: return rd;
    endcase
  endfunction

  function automatic req_t mk_req(input logic [7:0] op, input logic [31:0] addr,
                                  input logic [31:0] sdata, input int unsigned len);
    req_t r;
    r.wr    = m_store(op);
    r.size  = m_size(op);
    r.addr  = addr;
    r.wstrb = m_strb(op, addr[1:0]);
    r.wdata = m_wdata(op, sdata);
    r.len   = len;
    return r;
  endfunction

  // Memory model: accepts each request after its expected hold length and
  // answers dok_delay cycles later; shares rst with the DUT.
  initial begin : responder
    int unsigned req_cycles;
    int unsigned pend;
    req_t r;
    req_cycles = 0;
    pend = 0;
    data_addr_ok_i = 1'b0;
    data_data_ok_i = 1'b0;
    data_rdata_i   = '0;
    forever begin
      @(negedge clk);
      data_addr_ok_i = 1'b0;
      data_data_ok_i = 1'b0;
      if (rst) begin
        pend = 0;
        req_cycles = 0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          data_data_ok_i = 1'b1;
          data_rdata_i   = cur_rdata;
        end
      end else if (data_req_o) begin
        if (req_q.size() == 0) begin
          check("unexpected_req", {31'b0, data_req_o}, 32'h0);
        end else begin
          r = req_q[0];
          req_cycles++;
          check("req_wr", {31'b0, data_wr_o}, {31'b0, r.wr});
          check("req_size", {30'b0, data_size_o}, {30'b0, r.size});
          check("req_addr", data_addr_o, r.addr);
          check("req_wstrb", {28'b0, data_wstrb_o}, {28'b0, r.wstrb});
          if (r.wr) check("req_wdata", data_wdata_o, r.wdata);
          if (req_cycles >= r.len) begin
            data_addr_ok_i = 1'b1;
            void'(req_q.pop_front());
            req_cycles = 0;
            if (dok_delay == 0) begin
              data_data_ok_i = 1'b1;
              data_rdata_i   = cur_rdata;
            end else begin
              pend = dok_delay;
            end
          end
        end
      end
    end
  end

  // One aligned load/store through to DONE, then advance.
  task automatic do_op(input logic [7:0] op, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [31:0] rdata,
                       input int unsigned aok, input int unsigned dok,
                       input logic [31:0] exp_ld);
    int unsigned n;
    req_q.push_back(mk_req(op, addr, sdata, aok + 1));
    if (!m_store(op)) ld_q.push_back(exp_ld);
    dok_delay = dok;
    cur_rdata = rdata;
    @(negedge clk);
    valid_i = 1'b1; aluop_i = op; mem_addr_i = addr; store_data_i = sdata;
    exception_type_i = '0; regfile_write_enable_i = 1'b1;
    flush_i = 1'b0; advance_i = 1'b0;
    #1;
    check("exc_out", exception_type_o, 32'h0);
    check("bad_vaddr", bad_vaddr_o, 32'h0);
    check("rf_we", {31'b0, regfile_write_enable_o}, 32'h1);
    n = 0;
    while (mem_stall_request_o && n < 64) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("stall_cycles", 32'(n), 32'(aok + 2 + dok));
    if (!m_store(op) && ld_q.size() > 0) begin
      last_ld = ld_q.pop_front();
      check("load_data", load_data_o, last_ld);
    end
    check("req_pending", 32'(req_q.size()), 32'h0);
    advance_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; advance_i = 1'b0;
    #1;
    check("stall_after_adv", {31'b0, mem_stall_request_o}, 32'h0);
  endtask

  // An op that must not produce a request (exception, misaligned, flushed).
  task automatic no_req(input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] exc_in, input logic fl,
                        input logic [31:0] exp_exc, input logic [31:0] exp_bad,
                        input logic exp_we);
    @(negedge clk);
    valid_i = 1'b1; aluop_i = op; mem_addr_i = addr; store_data_i = 32'h5A5A5A5A;
    exception_type_i = exc_in; regfile_write_enable_i = 1'b1;
    flush_i = fl; advance_i = 1'b1;
    #1;
    check("nr_exc", exception_type_o, exp_exc);
    check("nr_bad", bad_vaddr_o, exp_bad);
    check("nr_we", {31'b0, regfile_write_enable_o}, {31'b0, exp_we});
    check("nr_stall", {31'b0, mem_stall_request_o}, 32'h0);
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0; advance_i = 1'b0; exception_type_i = '0;
    #1;
    check("nr_req", {31'b0, data_req_o}, 32'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] ops [8];
    rst = 1'b1; valid_i = 1'b0; aluop_i = '0; mem_addr_i = '0; store_data_i = '0;
    exception_type_i = '0; regfile_write_enable_i = 1'b0; advance_i = 1'b0;
    flush_i = 1'b0; dok_delay = 0; cur_rdata = '0; last_ld = '0;
    ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    repeat (3) @(negedge clk);
    #1;
    check("rst_req", {31'b0, data_req_o}, 32'h0);
    check("rst_stall", {31'b0, mem_stall_request_o}, 32'h0);
    check("rst_load", load_data_o, 32'h0);
    check("rst_addr", data_addr_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    do_op(OP_LW,  32'h80001004, 32'h0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF);
    do_op(OP_LB,  32'h80000003, 32'h0, 32'h80112233, 0, 0, 32'hFFFFFF80);
    do_op(OP_LBU, 32'h80000003, 32'h0, 32'h80112233, 1, 1, 32'h00000080);
    do_op(OP_LHU, 32'h80000002, 32'h0, 32'h80112233, 0, 2, 32'h00008011);
    do_op(OP_LH,  32'h80000002, 32'h0, 32'h80112233, 0, 0, 32'hFFFF8011);
    do_op(OP_SH,  32'h80000002, 32'h1234ABCD, 32'h0, 3, 1, 32'h0);
    do_op(OP_SB,  32'h80000001, 32'h000000A5, 32'h0, 0, 0, 32'h0);

    no_req(OP_LW, 32'h80000006, 32'h0, 1'b0, 32'h10000000, 32'h80000006, 1'b0);
    no_req(OP_SW, 32'h80000001, 32'h0, 1'b0, 32'h08000000, 32'h80000001, 1'b1);
    no_req(OP_LH, 32'h80000003, 32'h0, 1'b0, 32'h10000000, 32'h80000003, 1'b0);
    no_req(OP_SB, 32'h80000003, 32'h0, 1'b1, 32'h0, 32'h0, 1'b1);
    no_req(OP_LW, 32'h80000008, 32'h00000400, 1'b0, 32'h00000400, 32'h0, 1'b1);

    for (int i = 0; i < 12; i++) begin
      logic [7:0]  op;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] rd;
      int unsigned aok;
      int unsigned dok;
      op = ops[$urandom_range(0, 7)];
      a  = 32'h80000100 + 32'($urandom_range(0, 15));
      if (m_size(op) == 2'd1) a[0] = 1'b0;
      if (m_size(op) == 2'd2) a[1:0] = 2'b00;
      d   = $urandom;
      rd  = $urandom;
      aok = $urandom_range(0, 2);
      dok = $urandom_range(0, 2);
      do_op(op, a, d, rd, aok, dok, m_load(op, a[1:0], rd));
    end

    // Flush during WAIT: response absorbed, load result unchanged.
    do_op(OP_LW, 32'h80000020, 32'h0, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D);
    req_q.push_back(mk_req(OP_LW, 32'h80000010, 32'h0, 1));
    dok_delay = 3;
    cur_rdata = 32'h55555555;
    @(negedge clk);
    valid_i = 1'b1; aluop_i = OP_LW; mem_addr_i = 32'h80000010;
    exception_type_i = '0; regfile_write_enable_i = 1'b1;
    @(negedge clk);
    #1 check("fl_stall_req", {31'b0, mem_stall_request_o}, 32'h1);
    @(negedge clk);
    flush_i = 1'b1; valid_i = 1'b0;
    #1 check("fl_stall_wait", {31'b0, mem_stall_request_o}, 32'h1);
    @(negedge clk);
    flush_i = 1'b0;
    #1 check("fl_stall_hold", {31'b0, mem_stall_request_o}, 32'h1);
    @(negedge clk);
    #1 check("fl_stall_dok", {31'b0, mem_stall_request_o}, 32'h1);
    @(negedge clk);
    #1;
    check("fl_stall_end", {31'b0, mem_stall_request_o}, 32'h0);
    check("fl_load_kept", load_data_o, last_ld);
    do_op(OP_LW, 32'h80000014, 32'h0, 32'h01234567, 0, 0, 32'h01234567);

    // Reset while waiting for data_ok.
    req_q.push_back(mk_req(OP_LW, 32'h80000030, 32'h0, 1));
    dok_delay = 4;
    cur_rdata = 32'hAAAAAAAA;
    @(negedge clk);
    valid_i = 1'b1; aluop_i = OP_LW; mem_addr_i = 32'h80000030;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; valid_i = 1'b0;
    @(negedge clk);
    #1;
    check("rw_req", {31'b0, data_req_o}, 32'h0);
    check("rw_wr", {31'b0, data_wr_o}, 32'h0);
    check("rw_size", {30'b0, data_size_o}, 32'h0);
    check("rw_addr", data_addr_o, 32'h0);
    check("rw_wstrb", {28'b0, data_wstrb_o}, 32'h0);
    check("rw_wdata", data_wdata_o, 32'h0);
    check("rw_load", load_data_o, 32'h0);
    check("rw_stall", {31'b0, mem_stall_request_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_op(OP_LW, 32'h80000040, 32'h0, 32'h13579BDF, 1, 1, 32'h13579BDF);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM-stage data-memory access unit, sitting directly downstream of the execute stage; consumes its load/store aluop, effective address and store data.
- Checks alignment and issues one SRAM-like request per load/store (req / addr_ok / data_ok).
- Returns sign/zero-extended load data and stalls the pipeline until the access completes.
- Flags AdEL/AdES in the exception vector passed to writeback/CP0.

Parameters:
EXC_ADEL_BIT, 28, exception_type bit set on a misaligned load
EXC_ADES_BIT, 27, exception_type bit set on a misaligned store

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
valid_i  in  1  a MEM-stage instruction is present this cycle
aluop_i  in  8  ALUOP_* code from defines.vh
mem_addr_i  in  32  effective address (EX alu_data)
store_data_i  in  32  rt value (EX ram_write_data)
exception_type_i  in  32  exception vector from EX
regfile_write_enable_i  in  1  from EX
advance_i  in  1  pipeline moves MEM->WB at this edge
flush_i  in  1  exception/eret flush from CP0
data_req_o  out  1  request valid
data_wr_o  out  1  1=store
data_size_o  out  2  0=byte, 1=half, 2=word
data_addr_o  out  32  request address
data_wstrb_o  out  4  store byte enables
data_wdata_o  out  32  store data, lane-replicated
data_addr_ok_i  in  1  request accepted
data_data_ok_i  in  1  response/write complete
data_rdata_i  in  32  read data
load_data_o  out  32  extended load result
exception_type_o  out  32  exception_type_i plus AdEL/AdES
bad_vaddr_o  out  32  faulting address
regfile_write_enable_o  out  1  write enable, cleared on AdEL
mem_stall_request_o  out  1  hold upstream stages

Behaviour:
- mem op = LB, LBU, LH, LHU, LW, SB, SH, SW.
- Misaligned:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]!=0.
  - Byte ops never misaligned.
- Combinational exception logic:
  - exception_type_o = exception_type_i with EXC_ADEL_BIT (load) or EXC_ADES_BIT (store) ORed in when valid_i and misaligned.
  - bad_vaddr_o = mem_addr_i when misaligned, else 0.
  - regfile_write_enable_o = regfile_write_enable_i & ~AdEL.
- start = valid_i & mem op & ~misaligned & exception_type_i==0 & ~flush_i.
- FSM states and transitions:
  - IDLE: start -> REQ; latch addr, size, wr, wstrb, wdata, addr[1:0], aluop.
  - REQ: data_req_o=1; all request fields stable from latches.
    - addr_ok & data_ok same cycle -> DONE.
    - addr_ok only -> WAIT.
    - else stay.
  - WAIT: data_ok -> DONE; else stay.
  - DONE: advance_i or flush_i -> IDLE.
- Load data capture:
  - On data_ok, load_data_o is registered from data_rdata_i and the latched offset.
  - Byte select: rdata[8*off+7:8*off].
  - Half select: rdata[16*off[1]+15:16*off[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - load_data_o holds until the next capture.
- Store encoding:
  - SB: wstrb = 1<<off, wdata = {4{data[7:0]}}.
  - SH: wstrb = off[1]?1100:0011, wdata = {2{data[15:0]}}.
  - SW: wstrb = 1111, wdata = data.
  - Loads drive wstrb = 0000.
- mem_stall_request_o = (IDLE & start) | REQ | WAIT. It is low in DONE, so the instruction advances at the next edge.
- Latency: request visible 1 cycle after valid_i. With 0-wait memory (addr_ok & data_ok in the first REQ cycle), the instruction is in DONE 2 cycles after entry.
- Exceptions/misaligned: no request, no stall; FSM stays IDLE.
- Flush:
  - In REQ or WAIT, set cancel. Request fields stay held until addr_ok (a request is never withdrawn).
  - Stall stays asserted until data_ok.
  - Cancelled response: load_data_o not updated; state -> IDLE (not DONE).
- Flush and start in the same IDLE cycle: no request.
- DONE is entered only for the instruction that started; IDLE after advance prevents reissue.
- Reset (any state): state=IDLE, cancel=0, latches=0, load_data_o=0, data_req_o=0, data_wr_o=0, data_size_o=0, data_addr_o=0, data_wstrb_o=0, data_wdata_o=0, mem_stall_request_o=0. The memory interconnect shares rst, so no stale data_ok follows reset.

Test Plan:
- LW addr 0x80001004, addr_ok+data_ok on first REQ cycle, rdata 0xDEADBEEF -> req for 1 cycle, size=2, wstrb=0000; load_data_o=0xDEADBEEF; stall high exactly 2 cycles.
- LB addr 0x...03, rdata 0x80112233 -> 0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x...02 -> 0x00008011.
- SH addr 0x...02, data 0x1234ABCD, addr_ok delayed 3 cycles -> req held 4 cycles; addr/strb/wdata stable; wstrb=1100, wdata=0xABCDABCD, data_wr_o=1.
- LW addr 0x...06 -> no req, stall 0, exception_type_o[28]=1, bad_vaddr_o=0x...06, regfile_write_enable_o=0. SW addr 0x...01 -> bit 27 set.
- flush_i during WAIT, data_ok 2 cycles later -> stall held until data_ok; load_data_o unchanged; FSM IDLE; next LW issues normally.
- rst asserted in WAIT -> next cycle all outputs 0, state IDLE; subsequent LW completes normally.
